// File: rtl/ibex_prefetch_req_ctrl.sv
// ibex_prefetch_req_ctrl
//   Issues word-aligned instruction fetches on the core instruction bus.
//   Only one transaction is outstanding at a time. Responses made stale by
//   a branch are dropped. Valid responses are pushed, with their address,
//   into the downstream fetch FIFO.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_i                        fetching enabled
//   branch_i, addr_i             one-cycle redirect pulse and target address
//   instr_req_o/addr_o/gnt_i/rvalid_i/rdata_i   instruction bus
//   fifo_valid_o/addr_o/rdata_o/ready_i/clear_o FIFO input port and flush
//   busy_o                       a transaction is outstanding
module ibex_prefetch_req_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  input  logic        fifo_ready_i,
  output logic        fifo_clear_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic [31:0] addr_sel;
  logic        issue, req_raise, granted;
  logic        rst_q;

  assign issue    = req_i & fifo_ready_i;
  // A branch redirects the request in the same cycle.
  assign addr_sel = branch_i ? addr_i : fetch_addr_q;
  assign granted  = req_raise & instr_gnt_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= BOOT_ADDR;
      rsp_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      rsp_addr_q   <= rsp_addr_d;
    end
  end

  // Next state
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    rsp_addr_d   = rsp_addr_q;
    // Ungranted branch: remember the target; bit 1 survives so the first
    // pushed word carries the exact halfword target.
    if (branch_i) fetch_addr_d = {addr_i[31:1], 1'b0};
    if (granted) begin
      state_d      = WAIT_RVALID;
      rsp_addr_d   = addr_sel;
      fetch_addr_d = {addr_sel[31:2], 2'b00} + 32'd4;
    end else if (req_raise) begin
      state_d = WAIT_GNT;
    end else if (state_q == WAIT_RVALID || state_q == WAIT_ABORTED) begin
      if (instr_rvalid_i)  state_d = IDLE;
      else if (branch_i)   state_d = WAIT_ABORTED;
    end
  end

  // Outputs
  always_comb begin
    req_raise = 1'b0;
    case (state_q)
      IDLE:         req_raise = issue | branch_i;
      WAIT_GNT:     req_raise = 1'b1;
      WAIT_RVALID:  req_raise = instr_rvalid_i & (issue | branch_i);
      // Only reachable through a branch, so a redirect is always pending.
      WAIT_ABORTED: req_raise = instr_rvalid_i;
      default:      req_raise = 1'b0;
    endcase
    instr_req_o  = req_raise & ~rst_i;
    instr_addr_o = {addr_sel[31:2], 2'b00};
    fifo_valid_o = instr_rvalid_i & (state_q == WAIT_RVALID) & ~branch_i & ~rst_i;
    fifo_addr_o  = rsp_addr_q;
    fifo_rdata_o = instr_rdata_i;
    fifo_clear_o = branch_i & ~rst_i;
    busy_o       = (state_q != IDLE);
  end

  // A transaction abandoned by reset may answer in the first cycle after it.
  always_ff @(posedge clk_i) rst_q <= rst_i;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && !rst_q)
      assert (!(instr_rvalid_i && (state_q == IDLE || state_q == WAIT_GNT)))
        else $error("instr_rvalid_i with no granted request");
  end
`endif

endmodule

// File: tb/tb_ibex_prefetch_req_ctrl.sv
// Self-checking bench for ibex_prefetch_req_ctrl: directed test-plan
// sequences followed by random traffic against a transaction-level model.
module tb_ibex_prefetch_req_ctrl;
  logic        clk = 1'b0;
  logic        rst, req, branch, gnt, rvalid, fready;
  logic [31:0] addr, rdata;
  logic        ireq, fvalid, fclear, busy;
  logic [31:0] iaddr, faddr, frdata;

  int n_vec = 0, n_err = 0;

  // model: one granted request in flight (m_out), possibly stale,
  // or a request waiting for grant (m_wait)
  bit          m_out, m_stale, m_wait;
  logic [31:0] m_fetch, m_rsp;
  // last observed outputs, for directed constant checks
  logic        o_req, o_push, o_clear, o_busy;
  logic [31:0] o_addr, o_faddr;

  ibex_prefetch_req_ctrl dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .branch_i(branch), .addr_i(addr),
    .instr_req_o(ireq), .instr_addr_o(iaddr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .fifo_valid_o(fvalid), .fifo_addr_o(faddr), .fifo_rdata_o(frdata),
    .fifo_ready_i(fready), .fifo_clear_o(fclear), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit rq, input bit fr, input bit br,
                      input logic [31:0] ad, input bit g, input bit rv,
                      input logic [31:0] rd);
    bit          slot, e_req, e_push;
    logic [31:0] a;
    @(negedge clk);
    rst = r; req = rq; fready = fr; branch = br; addr = ad;
    gnt = g; rvalid = rv; rdata = rd;
    #1;
    a      = br ? ad : m_fetch;
    // a new request can go out when nothing is in flight, or as the
    // in-flight response lands
    slot   = (!m_out && !m_wait) || (m_out && rv);
    e_req  = m_wait || (slot && ((rq && fr) || br || m_stale));
    e_push = rv && m_out && !m_stale && !br;
    chk("instr_req",  ireq,   r ? 1'b0 : e_req);
    chk("instr_addr", iaddr,  {a[31:2], 2'b00});
    chk("fifo_valid", fvalid, r ? 1'b0 : e_push);
    chk("fifo_addr",  faddr,  m_rsp);
    chk("fifo_rdata", frdata, rd);
    chk("fifo_clear", fclear, r ? 1'b0 : br);
    chk("busy",       busy,   m_out || m_wait);
    o_req = ireq; o_addr = iaddr; o_push = fvalid; o_faddr = faddr;
    o_clear = fclear; o_busy = busy;
    @(posedge clk);
    if (r) begin
      m_out = 0; m_stale = 0; m_wait = 0; m_fetch = 32'h80; m_rsp = 0;
    end else if (e_req && g) begin
      m_out = 1; m_stale = 0; m_wait = 0; m_rsp = a;
      m_fetch = {a[31:2], 2'b00} + 32'd4;
    end else begin
      if (br) m_fetch = {ad[31:1], 1'b0};
      if (e_req) begin
        m_wait = 1; m_out = 0; m_stale = 0;
      end else if (m_out && rv) begin
        m_out = 0; m_stale = 0;
      end else if (m_out && br) begin
        m_stale = 1;
      end
    end
  endtask

  initial begin
    rst = 1; req = 0; fready = 0; branch = 0; addr = 0; gnt = 0; rvalid = 0; rdata = 0;
    m_out = 0; m_stale = 0; m_wait = 0; m_fetch = 32'h80; m_rsp = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0, 0);
    chk("rst_req", o_req, 1'b0);

    // boot stream
    step(0, 1, 1, 0, 0, 1, 0, 32'hA0);
    chk("boot_a0", o_addr, 32'h80);
    chk("boot_idle_busy", o_busy, 1'b0);
    step(0, 1, 1, 0, 0, 1, 1, 32'hA1);
    chk("boot_a1", o_addr, 32'h84);
    chk("boot_p0", o_faddr, 32'h80);
    step(0, 1, 1, 0, 0, 1, 1, 32'hA2);
    chk("boot_a2", o_addr, 32'h88);
    chk("boot_p1", o_faddr, 32'h84);
    step(0, 0, 1, 0, 0, 0, 1, 32'hA3);
    chk("boot_p2", o_faddr, 32'h88);
    chk("stop_req", o_req, 1'b0);

    // back-pressure, then grant stall
    step(0, 1, 0, 0, 0, 1, 0, 0);
    chk("bp_req", o_req, 1'b0);
    chk("bp_busy", o_busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0, i == 0, 1, 0, 0, 0, 0, 0);
      chk("stall_req", o_req, 1'b1);
      chk("stall_addr", o_addr, 32'h8C);
      chk("stall_push", o_push, 1'b0);
    end
    step(0, 1, 1, 0, 0, 1, 0, 0);
    chk("stall_gnt_addr", o_addr, 32'h8C);
    step(0, 1, 1, 0, 0, 1, 1, 32'hB0);
    chk("resume_push", o_faddr, 32'h8C);

    // branch while waiting for the 0x90 response
    step(0, 1, 1, 1, 32'h1002, 0, 0, 0);
    chk("br_clear", o_clear, 1'b1);
    chk("br_req", o_req, 1'b0);
    step(0, 1, 1, 0, 0, 1, 1, 32'hDEAD);
    chk("br_drop", o_push, 1'b0);
    chk("br_tgt", o_addr, 32'h1000);
    step(0, 1, 1, 0, 0, 1, 1, 32'hC0);
    chk("br_p0", o_faddr, 32'h1002);
    chk("br_a1", o_addr, 32'h1004);
    step(0, 1, 1, 0, 0, 0, 1, 32'hC1);
    chk("br_p1", o_faddr, 32'h1004);
    step(0, 1, 1, 0, 0, 1, 0, 0);

    // branch coincident with rvalid
    step(0, 1, 1, 1, 32'h200, 1, 1, 32'hBAD);
    chk("brrv_push", o_push, 1'b0);
    chk("brrv_addr", o_addr, 32'h200);
    chk("brrv_req", o_req, 1'b1);

    // address wrap
    step(0, 1, 1, 1, 32'hFFFF_FFFC, 1, 1, 0);
    chk("wrap_a0", o_addr, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 0, 1, 1, 32'hE0);
    chk("wrap_a1", o_addr, 32'h0);
    chk("wrap_p0", o_faddr, 32'hFFFF_FFFC);

    // reset mid-transaction, late rvalid ignored, restart at boot
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1, 32'hF0);
    chk("late_push", o_push, 1'b0);
    chk("late_addr", o_addr, 32'h80);
    step(0, 1, 1, 0, 0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bit          r, br, rv;
      logic [31:0] ad;
      r  = ($urandom_range(0, 99) < 2);
      br = ($urandom_range(0, 99) < 12);
      rv = m_out && ($urandom_range(0, 99) < 55);
      ad = $urandom;
      step(r, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 75, br, ad,
           $urandom_range(0, 99) < 60, rv, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end
endmodule

// File: doc/ibex_prefetch_req_ctrl.md
# ibex_prefetch_req_ctrl

Memory-request controller directly upstream of the instruction fetch FIFO inside the prefetch buffer. It issues word-aligned instruction fetches on the core's instruction bus and tracks the single outstanding transaction. It drops responses made stale by a branch, and pushes valid responses with their address into the FIFO's input port (`in_addr_i`/`in_rdata_i`/`in_valid_i`/`in_ready_o`) and its `clear_i`.

## Interface
- `BOOT_ADDR`, 32'h0000_0080: fetch address loaded at reset.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset: synchronous, active-high.
- `req_i`  in  1  fetching enabled; when low, no new requests are issued (an outstanding one completes).
- `branch_i`  in  1  one-cycle pulse: redirect fetch to `addr_i`.
- `addr_i`  in  32  branch target, halfword-aligned (bit 0 ignored).
- `instr_req_o`  out  1  bus request.
- `instr_addr_o`  out  32  bus address; bits [1:0] always 2'b00.
- `instr_gnt_i`  in  1  bus grant for the current request.
- `instr_rvalid_i`  in  1  response valid (at most one per granted request, never in the grant cycle).
- `instr_rdata_i`  in  32  response data.
- `fifo_valid_o`  out  1  push to FIFO (drives FIFO `in_valid_i`).
- `fifo_addr_o`  out  32  address of pushed word (drives `in_addr_i`).
- `fifo_rdata_o`  out  32  pushed data (equals `instr_rdata_i`).
- `fifo_ready_i`  in  1  FIFO can accept (from `in_ready_o`).
- `fifo_clear_o`  out  1  FIFO flush (drives `clear_i`).
- `busy_o`  out  1  transaction outstanding (state != IDLE).

## Operation
- Registers:
  - `fetch_addr_q` [31:0]: next fetch address. Bit 1 may be set only for the first fetch after a branch.
  - `rsp_addr_q` [31:0]: FIFO address of the outstanding request.
  - `state_q`.
- States:
  - IDLE: nothing outstanding.
  - WAIT_GNT: `instr_req_o` held until granted.
  - WAIT_RVALID: granted, awaiting a response to forward.
  - WAIT_ABORTED: granted, but the response is stale and must be dropped.
- Issue condition `issue = req_i & fifo_ready_i`. A new request is raised in:
  - IDLE, on `issue` or `branch_i`;
  - WAIT_RVALID or WAIT_ABORTED, in the cycle `instr_rvalid_i` is high and (`issue` or `branch_i`).
- `instr_req_o` is combinational. In WAIT_GNT it stays high regardless of `req_i`/`fifo_ready_i`.
- `instr_addr_o = {A[31:2],2'b00}`, where A is:
  - `addr_i` when `branch_i` is high;
  - otherwise `fetch_addr_q`.
- When a request is granted (`instr_req_o & instr_gnt_i`):
  - `rsp_addr_q <= A` (bit 1 preserved);
  - `fetch_addr_q <= {A[31:2],2'b00} + 4`, 32-bit wrap;
  - go to WAIT_RVALID.
- A request raised but not granted goes to WAIT_GNT.
- `branch_i` without a grant: `fetch_addr_q <= addr_i & ~1`.
- Forwarding:
  - `fifo_valid_o = instr_rvalid_i & (state_q == WAIT_RVALID) & ~branch_i`.
  - `fifo_addr_o = rsp_addr_q`; `fifo_rdata_o = instr_rdata_i`.
- `fifo_clear_o = branch_i`, combinational.
- Branch handling:
  - IDLE: the new request goes out in the same cycle.
  - WAIT_GNT: the address switches to the target in the same cycle (request stays high).
  - WAIT_RVALID, no `instr_rvalid_i`: go to WAIT_ABORTED and store the target.
  - WAIT_RVALID, with `instr_rvalid_i`: drop the data and issue the target in the same cycle.
  - WAIT_ABORTED: store the target (a later branch overrides an earlier one). When `instr_rvalid_i` arrives, drop it; if `issue` or a stored branch is pending, request `fetch_addr_q`.
- Response returns and nothing new is issued: go to IDLE.
- `instr_rvalid_i` in IDLE or WAIT_GNT is a protocol violation; flag it with an assertion and ignore it.

## Timing
- Reset (`rst_i` high at an edge):
  - `state_q = IDLE`, `fetch_addr_q = BOOT_ADDR`, `rsp_addr_q = 0`.
  - While `rst_i` is high, `instr_req_o`, `fifo_valid_o` and `fifo_clear_o` are forced to 0.
  - A reset in any state, including mid-transaction, abandons everything. A response arriving after reset deasserts is ignored (state IDLE).
- Request-to-push latency: request and grant in cycle N; `fifo_valid_o` in cycle N+1 at the earliest (same cycle as `instr_rvalid_i`).
- Throughput: with `gnt` in the request cycle and `rvalid` the next cycle, one word per cycle (rvalid cycle re-requests).
- `fifo_ready_i` is sampled only at request issue. Every granted non-aborted response is pushed unconditionally; the FIFO keeps one slot of slack.
- The cycle after `branch_i`, the FIFO is empty. The first pushed word carries the exact target address (bit 1 kept), so the FIFO aligns the halfword.

## Test plan
- Boot: release reset with `req_i=1`, `fifo_ready_i=1`, grant immediately, rvalid next cycle. Expect:
  - `instr_addr_o` 0x80, 0x84, 0x88 on consecutive cycles;
  - `fifo_addr_o` 0x80, 0x84, …, one cycle after each.
- Grant stall: hold `instr_gnt_i=0` for 3 cycles. Expect `instr_req_o` and `instr_addr_o=0x80` stable; no push until rvalid.
- Branch in WAIT_RVALID: outstanding request 0x84, `branch_i` with `addr_i=0x1002`. Expect:
  - `fifo_clear_o=1` that cycle;
  - the 0x84 response is not pushed;
  - next request to 0x1000, pushed with `fifo_addr_o=0x1002`, then 0x1004.
- Branch coincident with rvalid: `branch_i` (target 0x200) in the rvalid cycle. Expect no push and `instr_req_o` to 0x200 in the same cycle.
- Back-pressure: `fifo_ready_i=0` with nothing outstanding. Expect `instr_req_o=0` and `busy_o=0`; fetch resumes at the next address when ready rises.
- Wrap and reset: `addr_i=0xFFFF_FFFC`, then 0x0000_0000. Assert reset mid-WAIT_RVALID; expect the late rvalid ignored and the restart at 0x80.
